dmem_mmio_responder: RTL and testbench

- Target end of the core's data-memory interface. Responds to the initiator's dmem_addr/dmem_we/dmem_din with dmem_dout.
- Contains the word-addressed data RAM and a small MMIO window:
  - done/signature register
  - free-running cycle counter
  - transmit FIFO drained by an external valid/ready consumer
- Sits beside the processor wrapper at SoC top level. It owns the done flag, so the wrapper no longer computes it.

---
 rtl/dmem_mmio_responder_pkg.sv | 12 +
 rtl/dmem_mmio_responder_if.sv | 14 +
 rtl/dmem_mmio_responder_fifo.sv | 39 +++
 rtl/dmem_mmio_responder.sv | 83 ++++++++
 tb/tb_dmem_mmio_responder.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// rv_mem_pkg: MMIO register offsets, DONE magic value and TXSTAT bit layout
package rv_mem_pkg;
  localparam logic [3:0] DONE_OFF = 4'h0;
  localparam logic [3:0] CYC_OFF = 4'h4;
  localparam logic [3:0] TXD_OFF = 4'h8;
  localparam logic [3:0] TXS_OFF = 4'hC;
  localparam logic [31:0] DONE_MAGIC = 32'hDEAD_BEEF;
  localparam int TXS_EMPTY = 0;
  localparam int TXS_FULL = 1;
  localparam int TXS_OVF = 2;
  localparam int TXS_CNT = 8;
endpackage

// File: rtl/dmem_mmio_responder_if.sv
// dmem_mmio_responder_if: core data-memory bus (addr/we/din -> dout) plus TX stream (valid/data/ready).
// With DMEM_BUS_ERR_EN defined the bus also carries the load strobe dmem_re.
interface dmem_mmio_responder_if;
  logic [31:0] dmem_addr, dmem_din, dmem_dout, tx_data;
  logic dmem_we, tx_valid, tx_ready;
`ifdef DMEM_BUS_ERR_EN
  logic dmem_re;
  modport slave(input dmem_addr, dmem_we, dmem_din, dmem_re, tx_ready, output dmem_dout, tx_valid, tx_data);
  modport master(output dmem_addr, dmem_we, dmem_din, dmem_re, tx_ready, input dmem_dout, tx_valid, tx_data);
`else
  modport slave(input dmem_addr, dmem_we, dmem_din, tx_ready, output dmem_dout, tx_valid, tx_data);
  modport master(output dmem_addr, dmem_we, dmem_din, tx_ready, input dmem_dout, tx_valid, tx_data);
`endif
endinterface

// File: rtl/dmem_mmio_responder_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO; head is 0 while empty, no bypass of a push into an empty FIFO.
// Ports: clk, rst (async active-low), push/din, pop, head, full, empty, count (0..DEPTH).
module sync_fifo_fwft #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign do_push = push & (~full | do_pop);
  assign head = empty ? '0 : mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data RAM plus MMIO window (DONE, CYCLES, TXDATA, TXSTAT) behind the core's dmem bus.
// Ports: clk, rst (async active-low), bus (slave modport: dmem_addr/we/din/dout, tx_valid/data/ready), done_flag.
// Optional macro DMEM_BUS_ERR_EN adds output bus_err and bus input dmem_re.
module dmem_mmio_responder
  import rv_mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE = 32'h0000_2000
) (
  input  logic clk,
  input  logic rst,
  dmem_mmio_responder_if.slave bus,
  output logic done_flag
`ifdef DMEM_BUS_ERR_EN
  ,
  output logic bus_err
`endif
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  if (MEM_WORDS * 4 > MMIO_BASE) begin : g_map_check
    $error("dmem_mmio_responder: RAM overlaps MMIO window");
  end
  logic [31:0] ram [MEM_WORDS];
  logic [31:0] cyc, cyc_nxt, mmio_rd, txstat, head;
  logic [IW-1:0] idx;
  logic [1:0] sel;
  logic [CW-1:0] count;
  logic ram_hit, mmio_hit, full, empty, ovf, pop, wr_done, wr_txd, wr_txs;
  assign idx = bus.dmem_addr[IW+1:2];
  assign sel = bus.dmem_addr[3:2];
  assign ram_hit = bus.dmem_addr < 32'(MEM_WORDS * 4);
  assign mmio_hit = bus.dmem_addr[31:4] == MMIO_BASE[31:4];
  assign wr_done = bus.dmem_we & mmio_hit & (sel == DONE_OFF[3:2]);
  assign wr_txd = bus.dmem_we & mmio_hit & (sel == TXD_OFF[3:2]);
  assign wr_txs = bus.dmem_we & mmio_hit & (sel == TXS_OFF[3:2]);
  assign pop = bus.tx_valid & bus.tx_ready;
  assign cyc_nxt = cyc + 32'd1;
  assign bus.tx_valid = ~empty;
  assign bus.tx_data = head;
  always_comb begin
    txstat = '0;
    txstat[TXS_EMPTY] = empty;
    txstat[TXS_FULL] = full;
    txstat[TXS_OVF] = ovf;
    txstat[TXS_CNT+:8] = 8'(count);
  end
  assign mmio_rd = sel == DONE_OFF[3:2] ? {31'b0, done_flag}
                 : sel == CYC_OFF[3:2] ? cyc
                 : sel == TXS_OFF[3:2] ? txstat : '0;
  assign bus.dmem_dout = ram_hit ? ram[idx] : mmio_hit ? mmio_rd : '0;
  always_ff @(posedge clk) if (bus.dmem_we & ram_hit) ram[idx] <= bus.dmem_din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cyc <= '0;
      done_flag <= 1'b0;
      ovf <= 1'b0;
    end else begin
      cyc <= cyc_nxt;
      done_flag <= done_flag | (wr_done & (bus.dmem_din == DONE_MAGIC));
      // a dropped push in the same cycle as a TXSTAT write keeps overflow set
      ovf <= (wr_txd & full & ~pop) | (ovf & ~wr_txs);
    end
  sync_fifo_fwft #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(wr_txd),
    .pop(pop),
    .din(bus.dmem_din),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
`ifdef DMEM_BUS_ERR_EN
  logic miss;
  assign miss = ~ram_hit & ~mmio_hit;
  always_ff @(posedge clk or negedge rst)
    if (!rst) bus_err <= 1'b0;
    else bus_err <= bus_err | (miss & (bus.dmem_re | bus.dmem_we)) | (bus.dmem_we & mmio_hit & (sel == CYC_OFF[3:2]));
`endif
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed stimulus with queued expectations checked by a negedge monitor
module tb_dmem_mmio_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done_flag;
  logic [31:0] m_cyc;
  logic [31:0] ld_q[$];
  string ld_n[$];
  logic [31:0] tx_q[$];
  logic ld_en = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  dmem_mmio_responder_if bus_if();
`ifdef DMEM_BUS_ERR_EN
  logic bus_err;
  dmem_mmio_responder #(.MEM_WORDS(1024), .FIFO_DEPTH(8), .MMIO_BASE(32'h2000)) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .done_flag(done_flag), .bus_err(bus_err));
`else
  dmem_mmio_responder #(.MEM_WORDS(1024), .FIFO_DEPTH(8), .MMIO_BASE(32'h2000)) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .done_flag(done_flag));
`endif
  always @(posedge clk or negedge rst)
    if (!rst) m_cyc <= '0;
    else m_cyc <= m_cyc + 32'd1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (ld_en) begin
      if (ld_q.size() == 0) chk("ld_q_underflow", 32'd1, 32'd0);
      else chk(ld_n.pop_front(), bus_if.dmem_dout, ld_q.pop_front());
    end
    if (bus_if.tx_valid && bus_if.tx_ready) begin
      if (tx_q.size() == 0) chk("tx_unexpected", bus_if.tx_data, 32'hxxxx_xxxx);
      else chk("tx_word", bus_if.tx_data, tx_q.pop_front());
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ld(input string n, input logic [31:0] a, input logic [31:0] e);
    bus_if.dmem_addr = a;
    bus_if.dmem_we = 1'b0;
    ld_q.push_back(e);
    ld_n.push_back(n);
    ld_en = 1'b1;
    step();
    ld_en = 1'b0;
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d);
    bus_if.dmem_addr = a;
    bus_if.dmem_din = d;
    bus_if.dmem_we = 1'b1;
    step();
    bus_if.dmem_we = 1'b0;
  endtask
  task automatic drain();
    int k = 0;
    bus_if.tx_ready = 1'b1;
    while (bus_if.tx_valid && k < 40) begin
      step();
      k++;
    end
    chk("drain_bound", 32'(k < 40), 32'd1);
    bus_if.tx_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus_if.dmem_addr = '0;
    bus_if.dmem_din = '0;
    bus_if.dmem_we = 1'b0;
    bus_if.tx_ready = 1'b0;
`ifdef DMEM_BUS_ERR_EN
    bus_if.dmem_re = 1'b0;
`endif
    #1;
    chk("rst_done", 32'(done_flag), 32'd0);
    chk("rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
    chk("rst_tx_data", bus_if.tx_data, 32'd0);
    step();
    rst = 1'b1;
    ld("rst_txstat", 32'h200C, 32'h0000_0001);
    ld("rst_done_rd", 32'h2000, 32'd0);
    st(32'h0004, 32'h1234_5678);
    ld("ram_rd", 32'h0004, 32'h1234_5678);
    ld("ram_unaligned", 32'h0006, 32'h1234_5678);
    ld("miss_rd", 32'h1000, 32'd0);
    st(32'h0000, 32'h1111_1111);
    st(32'h1000, 32'h2222_2222);
    ld("miss_st_dropped", 32'h0000, 32'h1111_1111);
    ld("miss_rd2", 32'h1000, 32'd0);
    st(32'h0FFC, 32'hCAFE_F00D);
    ld("ram_last", 32'h0FFC, 32'hCAFE_F00D);
    ld("txd_rd_zero", 32'h2008, 32'd0);
    st(32'h2000, 32'hDEAD_BEEE);
    chk("done_wrong_magic", 32'(done_flag), 32'd0);
    st(32'h2000, 32'hDEAD_BEEF);
    chk("done_set", 32'(done_flag), 32'd1);
    st(32'h2000, 32'h0);
    chk("done_sticky", 32'(done_flag), 32'd1);
    ld("done_rd", 32'h2000, 32'd1);
    ld("cyc_a", 32'h2004, m_cyc);
    repeat (4) step();
    ld("cyc_b", 32'h2004, m_cyc);
    st(32'h2004, 32'h0);
    ld("cyc_wr_ignored", 32'h2004, m_cyc);
    force dut.cyc_nxt = 32'hFFFF_FFFF;
    step();
    release dut.cyc_nxt;
    ld("cyc_max", 32'h2004, 32'hFFFF_FFFF);
    ld("cyc_wrap", 32'h2004, 32'h0);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) tx_q.push_back(32'(i));
      st(32'h2008, 32'(i));
    end
    chk("tx_valid_full", 32'(bus_if.tx_valid), 32'd1);
    ld("txstat_ovf", 32'h200C, 32'h0000_0806);
    st(32'h200C, 32'h0);
    ld("txstat_clr", 32'h200C, 32'h0000_0802);
    drain();
    chk("tx_valid_drained", 32'(bus_if.tx_valid), 32'd0);
    ld("txstat_empty", 32'h200C, 32'h0000_0001);
    for (int i = 11; i <= 18; i++) begin
      tx_q.push_back(32'(i));
      st(32'h2008, 32'(i));
    end
    bus_if.tx_ready = 1'b1;
    tx_q.push_back(32'd19);
    st(32'h2008, 32'd19);
    bus_if.tx_ready = 1'b0;
    ld("txstat_full_pushpop", 32'h200C, 32'h0000_0802);
    drain();
    bus_if.tx_ready = 1'b1;
    bus_if.dmem_addr = 32'h2008;
    bus_if.dmem_din = 32'hA5;
    bus_if.dmem_we = 1'b1;
    tx_q.push_back(32'hA5);
    @(negedge clk);
    chk("no_bypass_valid", 32'(bus_if.tx_valid), 32'd0);
    step();
    bus_if.dmem_we = 1'b0;
    chk("fwft_valid", 32'(bus_if.tx_valid), 32'd1);
    chk("fwft_data", bus_if.tx_data, 32'hA5);
    step();
    chk("fwft_popped", 32'(bus_if.tx_valid), 32'd0);
    bus_if.tx_ready = 1'b0;
    st(32'h2008, 32'h77);
    chk("pre_rst_valid", 32'(bus_if.tx_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_done", 32'(done_flag), 32'd0);
    chk("midrst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
    chk("midrst_tx_data", bus_if.tx_data, 32'd0);
    step();
    rst = 1'b1;
    ld("post_rst_txstat", 32'h200C, 32'h0000_0001);
    ld("post_rst_cyc", 32'h2004, m_cyc);
    @(negedge clk);
    chk("ld_q_left", 32'(ld_q.size()), 32'd0);
    chk("tx_q_left", 32'(tx_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
